// File: rtl/dds_pkg.sv
// dds_pkg: shared constants for the DDS datapath (debounce window, one-hot waveform codes)
package dds_pkg;
   localparam logic [19:0] CNT_MAX     = 20'd999_999;
   localparam int          KEY_W       = 4;
   localparam logic [3:0]  WAVE_SINE   = 4'b0001;
   localparam logic [3:0]  WAVE_SQUARE = 4'b0010;
   localparam logic [3:0]  WAVE_TRI    = 4'b0100;
   localparam logic [3:0]  WAVE_SAW    = 4'b1000;
endpackage

// File: rtl/key_filter.sv
// key_filter: 2-FF synchroniser, saturating debounce counter and one-cycle press flag for one key
module key_filter #(
   parameter logic [19:0] CNT_MAX = dds_pkg::CNT_MAX
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic i_key,
   output logic o_flag
);
   logic [1:0]  r_sync;
   logic [19:0] r_cnt;
   logic        w_key_s;
   assign w_key_s = r_sync[1];
   // counter saturates at CNT_MAX so a held key passes CNT_MAX-1 only once
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         r_sync <= 2'b11;
         r_cnt  <= '0;
         o_flag <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_key};
         r_cnt  <= w_key_s ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 20'd1;
         o_flag <= !w_key_s && (r_cnt == CNT_MAX - 20'd1);
      end
endmodule

// File: rtl/key_wave_sel.sv
// key_wave_sel: debounced key array feeding a priority one-hot waveform select register
module key_wave_sel import dds_pkg::*; #(
   parameter logic [19:0] CNT_MAX = dds_pkg::CNT_MAX,
   parameter int          KEY_W   = dds_pkg::KEY_W
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] key_flag,
   output logic [KEY_W-1:0] wave_sel
);
   logic [KEY_W-1:0] w_sel;
   for (genvar g = 0; g < KEY_W; g++) begin : g_kf
      key_filter #(.CNT_MAX(CNT_MAX)) u_kf (
         .sys_clk  (sys_clk),
         .sys_rst_n(sys_rst_n),
         .i_key    (key[g]),
         .o_flag   (key_flag[g])
      );
   end
   // descending scan so the lowest flagged index ends up selected
   always_comb begin
      w_sel = wave_sel;
      for (int i = KEY_W - 1; i >= 0; i--)
         if (key_flag[i]) w_sel = KEY_W'(1) << i;
   end
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) wave_sel <= KEY_W'(WAVE_SINE);
      else            wave_sel <= w_sel;
endmodule

// File: tb/tb_key_wave_sel.sv
// tb_key_wave_sel: directed and random stimulus against a run-length model of the debounced key selector
module tb_key_wave_sel;
   localparam int CM = 9;
   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b1;
   logic [3:0] key = 4'hF;
   logic [3:0] key_flag;
   logic [3:0] wave_sel;
   int         n_chk = 0;
   int         n_fail = 0;
   int         m_h1 [4];
   int         m_h2 [4];
   logic [3:0] m_flag;
   logic [3:0] m_wave;

   key_wave_sel #(.CNT_MAX(20'd9), .KEY_W(4)) dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .key      (key),
      .key_flag (key_flag),
      .wave_sel (wave_sel)
   );

   always #5 sys_clk = ~sys_clk;

   // m_h1/m_h2: length of the current run of low raw samples, one and two edges ago.
   // A key fires once when the run seen through the two-edge synchroniser delay reaches CM.
   always @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_h1[i] <= 0;
            m_h2[i] <= 0;
         end
         m_flag <= 4'b0000;
         m_wave <= 4'b0001;
      end else begin
         for (int i = 0; i < 4; i++) begin
            m_h2[i]   <= m_h1[i];
            m_h1[i]   <= key[i] ? 0 : (m_h1[i] > CM ? m_h1[i] : m_h1[i] + 1);
            m_flag[i] <= (m_h2[i] == CM);
         end
         m_wave <= (m_flag == 4'b0000) ? m_wave : (m_flag & (~m_flag + 4'd1));
      end

   task automatic test_reset;
      key = 4'hF;
      #2 sys_rst_n = 1'b0;
      #1 n_chk++;
      if (wave_sel !== 4'b0001 || key_flag !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_assert wave=%b flag=%b want wave=0001 flag=0000", wave_sel, key_flag);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         n_chk++;
         if (wave_sel !== 4'b0001 || key_flag !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_hold c%0d wave=%b flag=%b want 0001/0000", c, wave_sel, key_flag);
         end
      end
      sys_rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge sys_clk);
         n_chk++;
         if (wave_sel !== 4'b0001 || key_flag !== 4'b0000 || m_wave !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_idle c%0d wave=%b flag=%b want 0001/0000", c, wave_sel, key_flag);
         end
      end
   endtask

   task automatic test_press_hold;
      int flag_at = -1;
      int sel_at = -1;
      int pulses = 0;
      key = 4'b1101;
      for (int c = 0; c < 30; c++) begin
         @(negedge sys_clk);
         n_chk++;
         if (key_flag !== m_flag || wave_sel !== m_wave) begin
            n_fail++;
            $display("FAIL press_hold c%0d flag=%b/%b wave=%b/%b", c, key_flag, m_flag, wave_sel, m_wave);
         end
         if (key_flag != 4'b0000) pulses++;
         if (key_flag == 4'b0010 && flag_at < 0) flag_at = c;
         if (wave_sel == 4'b0010 && sel_at < 0) sel_at = c;
      end
      n_chk++;
      if (flag_at !== 10 || sel_at !== 11 || pulses !== 1) begin
         n_fail++;
         $display("FAIL press_latency flag_at=%0d sel_at=%0d pulses=%0d want 10/11/1", flag_at, sel_at, pulses);
      end
      key = 4'hF;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic test_bounce;
      logic [3:0] seq [12];
      logic [3:0] w0;
      int pulses = 0;
      w0 = wave_sel;
      for (int c = 0; c < 12; c++) seq[c] = (c == 5 || c == 11) ? 4'hF : 4'b1011;
      for (int c = 0; c < 20; c++) begin
         key = (c < 12) ? seq[c] : 4'hF;
         @(negedge sys_clk);
         n_chk++;
         if (key_flag !== m_flag || wave_sel !== m_wave) begin
            n_fail++;
            $display("FAIL bounce c%0d flag=%b/%b wave=%b/%b", c, key_flag, m_flag, wave_sel, m_wave);
         end
         if (key_flag != 4'b0000) pulses++;
      end
      n_chk++;
      if (pulses !== 0 || wave_sel !== w0) begin
         n_fail++;
         $display("FAIL bounce_result pulses=%0d wave=%b want 0 and %b", pulses, wave_sel, w0);
      end
   endtask

   task automatic test_simultaneous;
      int seen = 0;
      key = 4'b0110;
      for (int c = 0; c < 20; c++) begin
         @(negedge sys_clk);
         n_chk++;
         if (key_flag !== m_flag || wave_sel !== m_wave) begin
            n_fail++;
            $display("FAIL simul c%0d flag=%b/%b wave=%b/%b", c, key_flag, m_flag, wave_sel, m_wave);
         end
         if (key_flag == 4'b1001) seen++;
      end
      n_chk++;
      if (seen !== 1 || wave_sel !== 4'b0001) begin
         n_fail++;
         $display("FAIL simul_result pulses=%0d wave=%b want 1 and 0001", seen, wave_sel);
      end
      key = 4'hF;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic test_reset_mid_press;
      int flag_at = -1;
      key = 4'b0111;
      repeat (7) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1 n_chk++;
      if (wave_sel !== 4'b0001 || key_flag !== 4'b0000) begin
         n_fail++;
         $display("FAIL midrst_assert wave=%b flag=%b want 0001/0000", wave_sel, key_flag);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         n_chk++;
         if (wave_sel !== 4'b0001 || key_flag !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_hold c%0d wave=%b flag=%b want 0001/0000", c, wave_sel, key_flag);
         end
      end
      sys_rst_n = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge sys_clk);
         n_chk++;
         if (key_flag !== m_flag || wave_sel !== m_wave) begin
            n_fail++;
            $display("FAIL midrst c%0d flag=%b/%b wave=%b/%b", c, key_flag, m_flag, wave_sel, m_wave);
         end
         if (key_flag == 4'b1000 && flag_at < 0) flag_at = c;
      end
      n_chk++;
      if (flag_at !== 10 || wave_sel !== 4'b1000) begin
         n_fail++;
         $display("FAIL midrst_result flag_at=%0d wave=%b want 10 and 1000", flag_at, wave_sel);
      end
      key = 4'hF;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic test_back_to_back;
      int pulses = 0;
      for (int c = 0; c < 40; c++) begin
         key = (c < 15 || (c >= 20 && c < 35)) ? 4'b1101 : 4'hF;
         @(negedge sys_clk);
         n_chk++;
         if (key_flag !== m_flag || wave_sel !== m_wave) begin
            n_fail++;
            $display("FAIL b2b c%0d flag=%b/%b wave=%b/%b", c, key_flag, m_flag, wave_sel, m_wave);
         end
         if (key_flag == 4'b0010) pulses++;
      end
      n_chk++;
      if (pulses !== 2 || wave_sel !== 4'b0010) begin
         n_fail++;
         $display("FAIL b2b_result pulses=%0d wave=%b want 2 and 0010", pulses, wave_sel);
      end
   endtask

   task automatic test_random;
      key = 4'hF;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 7) == 0) key = 4'($urandom);
         @(negedge sys_clk);
         n_chk++;
         if (key_flag !== m_flag || wave_sel !== m_wave || $countones(wave_sel) != 1) begin
            n_fail++;
            $display("FAIL random c%0d key=%b flag=%b/%b wave=%b/%b", c, key, key_flag, m_flag, wave_sel, m_wave);
         end
      end
      key = 4'hF;
      repeat (4) @(negedge sys_clk);
   endtask

   task automatic test_async_reset;
      key = 4'b1011;
      repeat (14) @(negedge sys_clk);
      n_chk++;
      if (wave_sel !== 4'b0100) begin
         n_fail++;
         $display("FAIL tri_select wave=%b want 0100", wave_sel);
      end
      #3 sys_rst_n = 1'b0;
      #1 n_chk++;
      if (wave_sel !== 4'b0001) begin
         n_fail++;
         $display("FAIL async_reset wave=%b want 0001", wave_sel);
      end
      key = 4'hF;
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
   endtask

   initial begin
      test_reset;
      test_press_hold;
      test_bounce;
      test_simultaneous;
      test_reset_mid_press;
      test_back_to_back;
      test_random;
      test_async_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
